// File: rtl/mpm_access_ctrl.sv
// mpm_access_ctrl: front end for the XOR multi-port memory.
//   After reset (or clr_start) it sweeps every word to CLEAR_VALUE, then in
//   RUN it passes client requests through, resolving same-cycle write
//   collisions and one-cycle write-after hazards with per-port ready.
// Ports:
//   clk, rst_n (async, active low)   clr_start -> restart clear sweep
//   busy        high during the sweep
//   cl_addr/cl_d/cl_we/cl_re[p]     client request
//   cl_ready[p] request accepted when (cl_we|cl_re) && cl_ready
//   cl_q/cl_qv[p] read data, one cycle after acceptance
//   conflict    pulse, cycle after a same-address write collision
//   mem_addr/mem_d/mem_en[p] -> memory, mem_q[p] <- memory (1-cycle latency)
// Optional build macro: MPM_RD_FWD_EN (forward previous-cycle write data to
//   reads instead of stalling them).
module mpm_access_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int PORTS = 2,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_start,
  output logic             busy,
  input  logic [AW-1:0]    cl_addr  [PORTS],
  input  logic [WIDTH-1:0] cl_d     [PORTS],
  input  logic             cl_we    [PORTS],
  input  logic             cl_re    [PORTS],
  output logic             cl_ready [PORTS],
  output logic [WIDTH-1:0] cl_q     [PORTS],
  output logic             cl_qv    [PORTS],
  output logic             conflict,
  output logic [AW-1:0]    mem_addr [PORTS],
  output logic [WIDTH-1:0] mem_d    [PORTS],
  output logic             mem_en   [PORTS],
  input  logic [WIDTH-1:0] mem_q    [PORTS]
);

  localparam int PW = AW + 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic            sweep_last;

  logic [AW-1:0]   hist_addr [PORTS];
  logic            hist_v    [PORTS];

  logic            wr    [PORTS];
  logic            rd    [PORTS];
  logic            hit   [PORTS];
  logic            coll  [PORTS];
  logic            ready [PORTS];
  logic            any_coll;
  logic            rd_acc [PORTS];

`ifdef MPM_RD_FWD_EN
  logic [WIDTH-1:0] hist_d  [PORTS];
  logic [WIDTH-1:0] fwd_val [PORTS];
  logic             fwd_q   [PORTS];
  logic [WIDTH-1:0] fwd_d   [PORTS];
`endif

  assign sweep_last = (int'(ptr) + PORTS) >= DEPTH;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (sweep_last) state_nxt = RUN;
      RUN:     if (clr_start)  state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // ---------------- sweep pointer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == CLEAR) begin
      ptr <= sweep_last ? '0 : ptr + PW'(PORTS);
    end else if (clr_start) begin
      ptr <= '0;
    end
  end

  // ---------------- request classification ----------------
  always_comb begin
    any_coll = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      wr[p]   = cl_we[p];
      rd[p]   = cl_re[p] && !cl_we[p];
      hit[p]  = 1'b0;
      coll[p] = 1'b0;
`ifdef MPM_RD_FWD_EN
      fwd_val[p] = '0;
`endif
      for (int unsigned k = 0; k < PORTS; k++) begin
        if (hist_v[k] && (hist_addr[k] == cl_addr[p]) && !hit[p]) begin
          hit[p] = 1'b1;
`ifdef MPM_RD_FWD_EN
          fwd_val[p] = hist_d[k];
`endif
        end
      end
      for (int unsigned i = 0; i < p; i++) begin
        if (cl_we[i] && cl_we[p] && (cl_addr[i] == cl_addr[p])) coll[p] = 1'b1;
      end
`ifdef MPM_RD_FWD_EN
      ready[p] = (state == RUN) && !coll[p] && !(hit[p] && wr[p]);
`else
      ready[p] = (state == RUN) && !coll[p] && !(hit[p] && (wr[p] || rd[p]));
`endif
      rd_acc[p] = rd[p] && ready[p];
      if (coll[p]) any_coll = 1'b1;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == CLEAR);
    for (int unsigned p = 0; p < PORTS; p++) begin
      cl_ready[p] = ready[p];
      if (state == CLEAR) begin
        mem_addr[p] = AW'(int'(ptr) + int'(p));
        mem_d[p]    = CLEAR_VALUE;
        mem_en[p]   = (int'(ptr) + int'(p)) < DEPTH;
      end else begin
        mem_addr[p] = cl_addr[p];
        mem_d[p]    = cl_d[p];
        mem_en[p]   = wr[p] && ready[p];
      end
`ifdef MPM_RD_FWD_EN
      cl_q[p] = cl_qv[p] ? (fwd_q[p] ? fwd_d[p] : mem_q[p]) : '0;
`else
      cl_q[p] = cl_qv[p] ? mem_q[p] : '0;
`endif
    end
  end

  // History tracks every write presented to the memory, sweep writes
  // included, since the memory commits all of them one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        hist_addr[p] <= '0;
        hist_v[p]    <= 1'b0;
        cl_qv[p]     <= 1'b0;
`ifdef MPM_RD_FWD_EN
        hist_d[p] <= '0;
        fwd_q[p]  <= 1'b0;
        fwd_d[p]  <= '0;
`endif
      end
    end else begin
      conflict <= (state == RUN) && any_coll;
      for (int unsigned p = 0; p < PORTS; p++) begin
        hist_addr[p] <= mem_addr[p];
        hist_v[p]    <= mem_en[p];
        cl_qv[p]     <= rd_acc[p];
`ifdef MPM_RD_FWD_EN
        hist_d[p] <= mem_d[p];
        fwd_q[p]  <= rd_acc[p] && hit[p];
        fwd_d[p]  <= fwd_val[p];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mpm_access_ctrl.sv
module tb_mpm_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_start;
  logic       busy;
  logic [7:0] cl_addr  [2];
  logic [7:0] cl_d     [2];
  logic       cl_we    [2];
  logic       cl_re    [2];
  logic       cl_ready [2];
  logic [7:0] cl_q     [2];
  logic       cl_qv    [2];
  logic       conflict;
  logic [7:0] mem_addr [2];
  logic [7:0] mem_d    [2];
  logic       mem_en   [2];
  logic [7:0] mem_q    [2];

  always #5 clk = ~clk;

  mpm_access_ctrl #(.WIDTH(8), .DEPTH(256), .PORTS(2), .CLEAR_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy),
    .cl_addr(cl_addr), .cl_d(cl_d), .cl_we(cl_we), .cl_re(cl_re),
    .cl_ready(cl_ready), .cl_q(cl_q), .cl_qv(cl_qv), .conflict(conflict),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .mem_q(mem_q)
  );

  // Memory model: registered read, writes land one cycle after presentation.
  logic [7:0] arr [256];
  logic       pend_en [2];
  logic [7:0] pend_a  [2];
  logic [7:0] pend_d  [2];

  initial begin
    for (int i = 0; i < 256; i++) arr[i] = 8'hEE;
    for (int p = 0; p < 2; p++) begin
      pend_en[p] = 1'b0; pend_a[p] = '0; pend_d[p] = '0; mem_q[p] = 8'hEE;
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      mem_q[p] <= arr[mem_addr[p]];
      if (pend_en[p]) arr[pend_a[p]] <= pend_d[p];
      pend_en[p] <= mem_en[p];
      pend_a[p]  <= mem_addr[p];
      pend_d[p]  <= mem_d[p];
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Read-data monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        if (cl_qv[p] === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_qv: port %0d got qv with data %0h, required no read pending", p, cl_q[p]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_port", p, e.port);
            chk($sformatf("rd_data_p%0d", p), cl_q[p], e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cl_addr[p] = '0; cl_d[p] = '0; cl_we[p] = 1'b0; cl_re[p] = 1'b0;
    end
  endtask

  task automatic set(input int p, input logic we, input logic re,
                     input logic [7:0] a, input logic [7:0] d);
    cl_we[p] = we; cl_re[p] = re; cl_addr[p] = a; cl_d[p] = d;
  endtask

  task automatic do_write(input int p, input logic [7:0] a, input logic [7:0] d);
    set(p, 1'b1, 1'b0, a, d);
    #1;
    chk($sformatf("wr_ready_p%0d", p), cl_ready[p], 1'b1);
    step();
    idle();
  endtask

  task automatic do_read(input int p, input logic [7:0] a, input logic [7:0] exp);
    exp_t e;
    set(p, 1'b0, 1'b1, a, 8'h00);
    #1;
    chk($sformatf("rd_ready_p%0d", p), cl_ready[p], 1'b1);
    e.port = p; e.data = exp;
    sb.push_back(e);
    step();
    idle();
    chk($sformatf("rd_qv_latency_p%0d", p), cl_qv[p], 1'b1);
  endtask

  task automatic sweep_check(input string nm);
    int n;
    bit bad;
    n = 0;
    bad = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      if (!(mem_en[0] === 1'b1 && mem_en[1] === 1'b1)) bad = 1'b1;
    end
    chk({nm, "_cycles"}, n, 128);
    chk({nm, "_mem_en"}, bad, 1'b0);
    chk({nm, "_ready"}, {cl_ready[1], cl_ready[0]}, 2'b11);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr_start = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_qv", {cl_qv[1], cl_qv[0]}, 2'b00);
    chk("rst_conflict", conflict, 1'b0);
    chk("rst_q", {cl_q[1], cl_q[0]}, 16'h0000);
    chk("rst_ptr", mem_addr[0], 8'h00);
    chk("rst_ready", {cl_ready[1], cl_ready[0]}, 2'b00);
    rst_n = 1'b1;
    sweep_check("sweep1");

    do_read(0, 8'h7F, 8'h00);

    // write then read two cycles later on the other port
    do_write(0, 8'h10, 8'h5A);
    step();
    do_read(1, 8'h10, 8'h5A);

    // same-cycle same-address write collision
    set(0, 1'b1, 1'b0, 8'h20, 8'h11);
    set(1, 1'b1, 1'b0, 8'h20, 8'h22);
    #1;
    chk("coll_ready0", cl_ready[0], 1'b1);
    chk("coll_ready1", cl_ready[1], 1'b0);
    step();
    idle();
    chk("coll_conflict", conflict, 1'b1);
    step();
    chk("coll_conflict_clr", conflict, 1'b0);
    do_read(0, 8'h20, 8'h11);

    // read immediately after a write to the same address
    do_write(0, 8'h40, 8'h33);
    set(1, 1'b0, 1'b1, 8'h40, 8'h00);
    #1;
`ifdef MPM_RD_FWD_EN
    chk("raw_ready_fwd", cl_ready[1], 1'b1);
    begin
      exp_t e;
      e.port = 1; e.data = 8'h33;
      sb.push_back(e);
    end
    step();
    idle();
`else
    chk("raw_stall", cl_ready[1], 1'b0);
    step();
    #1;
    chk("raw_retry_ready", cl_ready[1], 1'b1);
    begin
      exp_t e;
      e.port = 1; e.data = 8'h33;
      sb.push_back(e);
    end
    step();
    idle();
`endif
    chk("raw_qv", cl_qv[1], 1'b1);

    // write immediately after a write to the same address
    do_write(0, 8'h40, 8'h44);
    set(1, 1'b1, 1'b0, 8'h40, 8'h55);
    #1;
    chk("waw_stall", cl_ready[1], 1'b0);
    step();
    chk("waw_retry_ready", cl_ready[1], 1'b1);
    step();
    idle();
    step();
    do_read(0, 8'h40, 8'h55);

    // clear sweep on demand
    do_write(0, 8'h05, 8'hFF);
    step();
    clr_start = 1'b1;
    #1;
    chk("clr_busy_before", busy, 1'b0);
    step();
    clr_start = 1'b0;
    chk("clr_busy_after", busy, 1'b1);
    sweep_check("sweep2");
    do_read(0, 8'h05, 8'h00);

    // reset in the middle of a sweep
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (10) step();
    chk("mid_ptr", mem_addr[0], 8'd20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_ptr0", mem_addr[0], 8'd0);
    chk("mid_rst_ptr1", mem_addr[1], 8'd1);
    step();
    rst_n = 1'b1;
    sweep_check("sweep3");
    do_read(1, 8'h10, 8'h00);

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
